// File: rtl/riscv_mem_pkg.sv
// Shared memory-side types for the core's data path: word geometry and the
// store-buffer entry layout.
package riscv_mem_pkg;

  localparam int XLEN     = 32;
  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  // Word address of a byte address; sub-word bits never take part in matching.
  function automatic logic [XLEN-1:WORD_LSB] word_of(input logic [XLEN-1:0] byte_addr);
    return byte_addr[XLEN-1:WORD_LSB];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Load-to-store forwarding match: finds the youngest valid buffered store whose
// word address equals the load's word address.
module sb_fwd_match
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input  logic [XLEN-1:WORD_LSB]     word_addr,
  output logic                       hit,
  output logic [XLEN-1:0]            data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from the most recent slot (wr_ptr-1) back to the oldest; the first
  // match found is the youngest store to that word.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = wr_ptr - PW'(k);
      if (!hit && valid[idx] && (word_of(entries[idx].addr) == word_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a handshaked data memory:
// stores retire into a FIFO, drain oldest-first, and loads forward from it.
module store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = XLEN,
  parameter int DW    = XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     stall,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  output logic [AW-1:0]            mem_waddr,
  output logic [DW-1:0]            mem_wdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] valid;
  logic             full;
  logic             push;
  logic             pop;
  logic             hit;
  logic [XLEN-1:0]  fwd_data;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A slot freed by this cycle's drain is not reusable until the next edge,
  // so stall depends on full alone.
  assign stall = cpu_we & full;
  assign push  = cpu_we & ~full;
  assign pop   = ~empty & mem_wready;

  assign mem_wvalid = ~empty;
  assign mem_waddr  = AW'(entries[rd_ptr].addr);
  assign mem_wdata  = DW'(entries[rd_ptr].data);
  assign mem_raddr  = cpu_addr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) valid[i] = entries[i].valid;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the entry array is reset in full; valid must clear on reset, and
  // clearing addr/data as well keeps mem_waddr/mem_wdata defined from reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= '{valid: 1'b1, addr: XLEN'(cpu_addr), data: XLEN'(cpu_wdata)};
        wr_ptr          <= wr_ptr + PW'(1);
      end
      // push and pop never address the same slot: a pop needs a non-empty
      // FIFO, and a push into rd_ptr would need it full.
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .entries   (entries),
    .valid     (valid),
    .wr_ptr    (wr_ptr),
    .word_addr (word_of(XLEN'(cpu_addr))),
    .hit       (hit),
    .data      (fwd_data)
  );

  // The head being drained this cycle still forwards: memory only takes the
  // new value at the same edge that retires the entry.
  assign cpu_rdata = hit ? DW'(fwd_data) : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        empty;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  st_t sb_q[$];     // reference model: pending stores, oldest first
  st_t dut_log[$];  // writes the DUT actually handed to memory

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && mem_wvalid && mem_wready) dut_log.push_back('{mem_waddr, mem_wdata});
  end

  // Expected load data: the last (youngest) pending store to the same word, else memory.
  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [31:0] mr);
    logic [31:0] r;
    r = mr;
    foreach (sb_q[i]) if ((sb_q[i].addr >> 2) == (a >> 2)) r = sb_q[i].data;
    return r;
  endfunction

  // One clock: update the model with the inputs the DUT sampled, then return at the negedge.
  task automatic advance();
    bit do_pop;
    bit do_push;
    @(posedge clk);
    if (!reset) begin
      sb_q.delete();
    end else begin
      do_pop  = (sb_q.size() > 0) && mem_wready;
      do_push = cpu_we && (sb_q.size() < DEPTH);
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back('{cpu_addr, cpu_wdata});
    end
    @(negedge clk);
  endtask

  task automatic drain_all();
    int guard;
    cpu_we     = 1'b0;
    mem_wready = 1'b1;
    guard      = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      advance();
      guard++;
    end
    #1;
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%0b want 1", empty);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    cpu_we     = 1'b1;
    cpu_addr   = 32'h40;
    cpu_wdata  = 32'h1234;
    mem_wready = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({empty, stall, mem_wvalid, count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got empty=%0b stall=%0b wvalid=%0b count=%0d want 1 0 0 0",
               empty, stall, mem_wvalid, count);
    end
    @(negedge clk);
    reset  = 1'b1;
    cpu_we = 1'b0;
    sb_q.delete();
    advance();
    #1;
    n_checks++;
    if (count !== 3'd0 || mem_wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_enqueue: got count=%0d wvalid=%0b want 0 0", count, mem_wvalid);
    end
  endtask

  task automatic test_single_store();
    mem_wready = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 32'hA0;
    cpu_wdata  = 32'd5;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL single_stall: got %0b want 0", stall);
    end
    advance();
    cpu_we = 1'b0;
    #1;
    n_checks++;
    if ({mem_wvalid, mem_waddr, mem_wdata, count} !== {1'b1, 32'hA0, 32'd5, 3'd1}) begin
      n_fail++;
      $display("FAIL single_present: got wvalid=%0b waddr=%h wdata=%h count=%0d want 1 a0 5 1",
               mem_wvalid, mem_waddr, mem_wdata, count);
    end
    advance();
    #1;
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drained: got empty=%0b want 1", empty);
    end
  endtask

  task automatic test_fill_stall();
    logic [31:0] order [4];
    order      = '{32'h04, 32'h08, 32'h0C, 32'h10};
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_we    = 1'b1;
      cpu_addr  = 32'(i * 4);
      cpu_wdata = 32'h100 + 32'(i);
      advance();
    end
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h555;
    #1;
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_count: got %0d want 4", count);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_stall_held cycle %0d: got %0b want 1", c, stall);
      end
      advance();
    end
    mem_wready = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1 || mem_waddr !== 32'h00) begin
      n_fail++;
      $display("FAIL fill_stall_during_drain: got stall=%0b waddr=%h want 1 0", stall, mem_waddr);
    end
    advance();
    mem_wready = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_accept_next: got stall=%0b want 0", stall);
    end
    advance();
    cpu_we     = 1'b0;
    mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (mem_wvalid !== 1'b1 || mem_waddr !== order[i]) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: got wvalid=%0b waddr=%h want 1 %h", i, mem_wvalid, mem_waddr, order[i]);
      end
      advance();
    end
    #1;
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_final_empty: got %0b want 1", empty);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] loads [3];
    logic [31:0] wants [3];
    loads      = '{32'h50, 32'h52, 32'h54};
    wants      = '{32'h2, 32'h2, 32'hDEAD};
    mem_wready = 1'b0;
    mem_rdata  = 32'hDEAD;
    cpu_we     = 1'b1;
    cpu_addr   = 32'h50;
    cpu_wdata  = 32'h1;
    #1;
    n_checks++;
    if (cpu_rdata !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL fwd_same_cycle_invisible: got %h want dead", cpu_rdata);
    end
    advance();
    cpu_wdata = 32'h2;
    advance();
    cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = loads[i];
      #1;
      n_checks++;
      if (cpu_rdata !== wants[i] || mem_raddr !== loads[i]) begin
        n_fail++;
        $display("FAIL fwd_load %h: got rdata=%h raddr=%h want %h %h",
                 loads[i], cpu_rdata, mem_raddr, wants[i], loads[i]);
      end
      @(negedge clk);
    end
    // Drain the older 0x50 store; then the last entry forwards while it is accepted.
    mem_wready = 1'b1;
    advance();
    cpu_addr = 32'h50;
    #1;
    n_checks++;
    if (cpu_rdata !== 32'h2 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL fwd_head_accepting: got rdata=%h count=%0d want 2 1", cpu_rdata, count);
    end
    drain_all();
  endtask

  task automatic test_wrap_toggle();
    st_t exp_log[$];
    bit  accepted;
    bit  toggle;
    int  tries;
    dut_log.delete();
    toggle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_we    = 1'b1;
      cpu_addr  = 32'h200 + 32'(i * 4);
      cpu_wdata = $urandom;
      exp_log.push_back('{cpu_addr, cpu_wdata});
      accepted = 1'b0;
      tries    = 0;
      while (!accepted && tries < 20) begin
        mem_wready = toggle;
        toggle     = ~toggle;
        #1;
        n_checks++;
        if (count !== 3'(sb_q.size()) || count > 3'd4 || stall !== (sb_q.size() == DEPTH) ||
            mem_wvalid !== (sb_q.size() != 0) ||
            (sb_q.size() != 0 && (mem_waddr !== sb_q[0].addr || mem_wdata !== sb_q[0].data))) begin
          n_fail++;
          $display("FAIL wrap_state store %0d: got count=%0d stall=%0b wvalid=%0b waddr=%h want count=%0d",
                   i, count, stall, mem_wvalid, mem_waddr, sb_q.size());
        end
        accepted = (sb_q.size() < DEPTH);
        advance();
        tries++;
      end
      if (!accepted) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_timeout store %0d: got stuck want accepted", i);
      end
    end
    drain_all();
    n_checks++;
    if (dut_log.size() != exp_log.size()) begin
      n_fail++;
      $display("FAIL wrap_log_size: got %0d want %0d", dut_log.size(), exp_log.size());
    end else begin
      foreach (exp_log[i]) begin
        n_checks++;
        if (dut_log[i].addr !== exp_log[i].addr || dut_log[i].data !== exp_log[i].data) begin
          n_fail++;
          $display("FAIL wrap_log[%0d]: got %h/%h want %h/%h",
                   i, dut_log[i].addr, dut_log[i].data, exp_log[i].addr, exp_log[i].data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_we    = 1'b1;
      cpu_addr  = 32'h400 + 32'(i * 4);
      cpu_wdata = 32'hA00 + 32'(i);
      advance();
    end
    cpu_we = 1'b0;
    #1;
    n_checks++;
    if (mem_wvalid !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL middrain_pending: got wvalid=%0b count=%0d want 1 3", mem_wvalid, count);
    end
    dut_log.delete();
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_wvalid !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL middrain_async: got wvalid=%0b empty=%0b want 0 1", mem_wvalid, empty);
    end
    mem_wready = 1'b1;
    advance();
    reset = 1'b1;
    repeat (4) advance();
    #1;
    n_checks++;
    if (dut_log.size() != 0 || mem_wvalid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL middrain_no_writes: got writes=%0d wvalid=%0b count=%0d want 0 0 0",
               dut_log.size(), mem_wvalid, count);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      cpu_we     = ($urandom_range(0, 99) < 60);
      cpu_addr   = 32'h300 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
      cpu_wdata  = $urandom;
      mem_wready = ($urandom_range(0, 99) < 45);
      mem_rdata  = $urandom;
      #1;
      n_checks++;
      if (cpu_rdata !== exp_rdata(cpu_addr, mem_rdata) || count !== 3'(sb_q.size()) ||
          stall !== (cpu_we && sb_q.size() == DEPTH) || empty !== (sb_q.size() == 0) ||
          (sb_q.size() != 0 && (mem_waddr !== sb_q[0].addr || mem_wdata !== sb_q[0].data))) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random cycle %0d: got rdata=%h count=%0d stall=%0b waddr=%h want rdata=%h count=%0d",
                   c, cpu_rdata, count, stall, mem_waddr, exp_rdata(cpu_addr, mem_rdata), sb_q.size());
      end
      advance();
    end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill_stall();
    test_forwarding();
    test_wrap_toggle();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
